// File: rtl/aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer
//
// Purpose: control sequencer for an iterative AES encryption datapath. It
// turns a rising edge of `start` into the step sequence for key expansion,
// the initial AddRoundKey, NR-1 full rounds, the final round (no
// MixColumns) and a one-cycle ciphertext-valid pulse. All outputs are
// registered (Moore). Each output is computed from the next state and
// registered on the same clock edge as the state.
//
// Optional feature (compile-time macro AES_KEY_CACHE_EN):
//   When defined, a key-valid flag remembers that the round keys are
//   already expanded. A start edge with the flag set skips KEXP. The flag
//   is set on leaving KEXP and is cleared by key_new in any state. When
//   key_new arrives in the last KEXP cycle, the clear takes priority.
//   When undefined, KEXP always runs and key_new is ignored.
//
// Parameters:
//   NR               number of AES rounds (10 = AES-128), legal 2..15
//
// Ports:
//   clk              clock, rising-edge active
//   rst_             asynchronous active-low reset
//   start            encryption request; only a low->high edge seen in
//                    IDLE starts a run
//   key_new          one-cycle pulse: key register was rewritten
//   transformer_done 1 = idle/ready, 0 = busy
//   kexp_en          key-expansion step enable
//   kexp_step        round key being generated (1..NR), else 0
//   ld_init          load state with plaintext ^ round key 0
//   round            current round / round-key select, else 0
//   sub_shift_en     SubBytes + ShiftRows enable
//   mix_en           MixColumns enable
//   ark_en           AddRoundKey enable
//   out_valid        one-cycle pulse: ciphertext valid
// ---------------------------------------------------------------------------
module aes_round_sequencer #(
    parameter int NR = 10
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic       start,
    input  logic       key_new,
    output logic       transformer_done,
    output logic       kexp_en,
    output logic [3:0] kexp_step,
    output logic       ld_init,
    output logic [3:0] round,
    output logic       sub_shift_en,
    output logic       mix_en,
    output logic       ark_en,
    output logic       out_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEXP,
        S_INIT,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    localparam logic [3:0] NR_L    = 4'(NR);
    localparam logic [3:0] NR_M1_L = 4'(NR - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       start_q;
    logic       start_edge;
    logic       key_valid;

    logic       done_q, done_d;
    logic       kexp_en_q, kexp_en_d;
    logic [3:0] kexp_step_q, kexp_step_d;
    logic       ld_init_q, ld_init_d;
    logic [3:0] round_q, round_d;
    logic       ss_q, ss_d;
    logic       mix_q, mix_d;
    logic       ark_q, ark_d;
    logic       ov_q, ov_d;

    // start_q tracks start every cycle. A level held high across a whole
    // run therefore cannot look like a fresh edge when the FSM returns to IDLE.
    assign start_edge = start & ~start_q;

`ifdef AES_KEY_CACHE_EN
    logic key_valid_q, key_valid_d;

    always_comb begin
        key_valid_d = key_valid_q;
        if (state_q == S_KEXP && cnt_q == NR_L) begin
            key_valid_d = 1'b1;
        end
        // A key rewrite invalidates the expanded keys, even in the same
        // cycle that expansion finishes.
        if (key_new) begin
            key_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            key_valid_q <= 1'b0;
        end else begin
            key_valid_q <= key_valid_d;
        end
    end

    assign key_valid = key_valid_q;
`else
    logic unused_key_new;
    assign unused_key_new = key_new;
    assign key_valid      = 1'b0;
`endif

    // Next-state and counter logic. cnt_q holds kexp_step in KEXP and the
    // round number in INIT/ROUND/FINAL.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    if (key_valid) begin
                        state_d = S_INIT;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = S_KEXP;
                        cnt_d   = 4'd1;
                    end
                end
            end
            S_KEXP: begin
                if (cnt_q == NR_L) begin
                    state_d = S_INIT;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_INIT: begin
                state_d = S_ROUND;
                cnt_d   = 4'd1;
            end
            S_ROUND: begin
                if (cnt_q == NR_M1_L) begin
                    state_d = S_FINAL;
                    cnt_d   = NR_L;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_FINAL: begin
                state_d = S_DONE;
                cnt_d   = 4'd0;
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Moore outputs decoded from the next state. They are registered
    // together with the state, so each output matches its state in the
    // same cycle.
    always_comb begin
        done_d      = (state_d == S_IDLE);
        kexp_en_d   = (state_d == S_KEXP);
        kexp_step_d = (state_d == S_KEXP) ? cnt_d : 4'd0;
        ld_init_d   = (state_d == S_INIT);
        round_d     = (state_d == S_ROUND || state_d == S_FINAL) ? cnt_d : 4'd0;
        ss_d        = (state_d == S_ROUND || state_d == S_FINAL);
        mix_d       = (state_d == S_ROUND);
        ark_d       = (state_d == S_ROUND || state_d == S_FINAL);
        ov_d        = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            start_q     <= 1'b0;
            done_q      <= 1'b1;
            kexp_en_q   <= 1'b0;
            kexp_step_q <= 4'd0;
            ld_init_q   <= 1'b0;
            round_q     <= 4'd0;
            ss_q        <= 1'b0;
            mix_q       <= 1'b0;
            ark_q       <= 1'b0;
            ov_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            start_q     <= start;
            done_q      <= done_d;
            kexp_en_q   <= kexp_en_d;
            kexp_step_q <= kexp_step_d;
            ld_init_q   <= ld_init_d;
            round_q     <= round_d;
            ss_q        <= ss_d;
            mix_q       <= mix_d;
            ark_q       <= ark_d;
            ov_q        <= ov_d;
        end
    end

    assign transformer_done = done_q;
    assign kexp_en          = kexp_en_q;
    assign kexp_step        = kexp_step_q;
    assign ld_init          = ld_init_q;
    assign round            = round_q;
    assign sub_shift_en     = ss_q;
    assign mix_en           = mix_q;
    assign ark_en           = ark_q;
    assign out_valid        = ov_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes_round_sequencer
//
// Self-checking bench for aes_round_sequencer.
//
// Reference model: an encryption run is treated as a timeline of phase
// numbers. Phase 1..NR is key expansion, NR+1 is the initial load,
// NR+2..2NR are the full rounds, 2NR+1 is the final round and 2NR+2 is the
// output pulse. A run that uses cached keys enters this timeline at phase
// NR+1. The expected outputs are computed from the phase number.
//
// Stimulus: directed sequences followed by a randomized phase. The
// randomized phase toggles start, pulses key_new and occasionally asserts
// reset. The AES_KEY_CACHE_EN macro selects the matching model behaviour.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aes_round_sequencer;

    localparam int NR = 10;

    logic       clk;
    logic       rst_;
    logic       start;
    logic       key_new;
    logic       transformer_done;
    logic       kexp_en;
    logic [3:0] kexp_step;
    logic       ld_init;
    logic [3:0] round;
    logic       sub_shift_en;
    logic       mix_en;
    logic       ark_en;
    logic       out_valid;

    aes_round_sequencer #(.NR(NR)) dut (
        .clk              (clk),
        .rst_             (rst_),
        .start            (start),
        .key_new          (key_new),
        .transformer_done (transformer_done),
        .kexp_en          (kexp_en),
        .kexp_step        (kexp_step),
        .ld_init          (ld_init),
        .round            (round),
        .sub_shift_en     (sub_shift_en),
        .mix_en           (mix_en),
        .ark_en           (ark_en),
        .out_valid        (out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec  = 0;
    int n_miss = 0;
    int ov_cnt = 0;

    // Model state
    int p          = 0;
    bit start_prev = 1'b0;
    bit kv         = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Packed output order:
    // done, kexp_en, kexp_step[3:0], ld_init, round[3:0], ss, mix, ark, ov
    function automatic logic [14:0] exp_out(input int q);
        logic       e_done, e_ken, e_ld, e_ss, e_mix, e_ark, e_ov;
        logic [3:0] e_kstep, e_round;
        e_done  = (q == 0);
        e_ken   = (q >= 1 && q <= NR);
        e_kstep = e_ken ? 4'(q) : 4'd0;
        e_ld    = (q == NR + 1);
        if (q >= NR + 2 && q <= 2 * NR)  e_round = 4'(q - NR - 1);
        else if (q == 2 * NR + 1)        e_round = 4'(NR);
        else                             e_round = 4'd0;
        e_ss    = (q >= NR + 2 && q <= 2 * NR + 1);
        e_mix   = (q >= NR + 2 && q <= 2 * NR);
        e_ark   = e_ss;
        e_ov    = (q == 2 * NR + 2);
        return {e_done, e_ken, e_kstep, e_ld, e_round, e_ss, e_mix, e_ark, e_ov};
    endfunction

    function automatic logic [14:0] dut_vec();
        return {transformer_done, kexp_en, kexp_step, ld_init, round,
                sub_shift_en, mix_en, ark_en, out_valid};
    endfunction

    task automatic model_step();
        int old_p;
        old_p = p;
        if (old_p == 0 && start && !start_prev) begin
            p = kv ? NR + 1 : 1;
        end else if (old_p != 0) begin
            p = (old_p == 2 * NR + 2) ? 0 : old_p + 1;
        end
`ifdef AES_KEY_CACHE_EN
        if (old_p == NR) kv = 1'b1;
        if (key_new)     kv = 1'b0;
`endif
        start_prev = start;
    endtask

    task automatic model_reset();
        p          = 0;
        start_prev = 1'b0;
        kv         = 1'b0;
    endtask

    // One clock cycle: update the model at the edge, then compare the DUT outputs 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("cycle", 32'(dut_vec()), 32'(exp_out(p)));
        if (out_valid) ov_cnt++;
    endtask

    // Assert reset between clock edges. Then check the asynchronous effect and hold reset across one edge.
    task automatic apply_reset();
        #3;
        rst_ = 1'b0;
        #1;
        model_reset();
        check_eq("rst_async", 32'(dut_vec()), 32'(exp_out(0)));
        @(posedge clk);
        #1;
        check_eq("rst_hold", 32'(dut_vec()), 32'(exp_out(0)));
        #2;
        rst_ = 1'b1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (transformer_done) break;
            tick();
        end
        check_eq("idle_reached", 32'(transformer_done), 32'd1);
    endtask

    // Start one run from a quiet start line and count the busy cycles.
    task automatic run_measure(output int busy);
        start = 1'b0;
        tick();
        start = 1'b1;
        busy  = 0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (transformer_done) break;
            busy++;
            tick();
        end
    endtask

    task automatic pulse_key_new();
        key_new = 1'b1;
        tick();
        key_new = 1'b0;
    endtask

    int busy;
    int r;

    initial begin
        rst_    = 1'b0;
        start   = 1'b0;
        key_new = 1'b0;
        #12;
        check_eq("reset_state", 32'(dut_vec()), 32'(exp_out(0)));
        #1;
        rst_ = 1'b1;

        // Single uncached run: full 22-cycle timeline
        run_measure(busy);
        check_eq("busy_full", 32'(busy), 32'(2 * NR + 2));

        // start held high for 40 cycles gives one output pulse
        start = 1'b0;
        tick();
        ov_cnt = 0;
        start  = 1'b1;
        repeat (40) tick();
        start = 1'b0;
        repeat (3) tick();
        check_eq("held_start_pulses", 32'(ov_cnt), 32'd1);

        // A second edge while busy is ignored
        ov_cnt = 0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (25) tick();
        check_eq("busy_edge_pulses", 32'(ov_cnt), 32'd1);

        // Reset during round 5 aborts the run without an output pulse
        pulse_key_new();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (round == 4'd5) break;
            tick();
        end
        check_eq("reached_round5", 32'(round), 32'd5);
        ov_cnt = 0;
        apply_reset();
        repeat (25) tick();
        check_eq("abort_no_ov", 32'(ov_cnt), 32'd0);
        run_measure(busy);
        check_eq("busy_after_abort", 32'(busy), 32'(2 * NR + 2));

`ifdef AES_KEY_CACHE_EN
        // Back-to-back runs reuse the expanded keys
        pulse_key_new();
        run_measure(busy);
        check_eq("cache_first", 32'(busy), 32'(2 * NR + 2));
        run_measure(busy);
        check_eq("cache_second", 32'(busy), 32'(NR + 2));
        pulse_key_new();
        run_measure(busy);
        check_eq("newkey_first", 32'(busy), 32'(2 * NR + 2));
        pulse_key_new();
        run_measure(busy);
        check_eq("newkey_second", 32'(busy), 32'(2 * NR + 2));
`else
        // Without caching, every run expands the key
        run_measure(busy);
        check_eq("nocache_second", 32'(busy), 32'(2 * NR + 2));
        pulse_key_new();
        run_measure(busy);
        check_eq("nocache_keynew", 32'(busy), 32'(2 * NR + 2));
`endif

        // key_new in the last KEXP cycle leaves the next run uncached
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (NR - 1) tick();
        check_eq("last_kexp_step", 32'(kexp_step), 32'(NR));
        key_new = 1'b1;
        tick();
        key_new = 1'b0;
        wait_idle();
        run_measure(busy);
        check_eq("busy_after_late_keynew", 32'(busy), 32'(2 * NR + 2));

        // Randomized phase
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 199);
            if (r == 0) begin
                apply_reset();
            end else begin
                if ($urandom_range(0, 7) == 0) start = ~start;
                key_new = ($urandom_range(0, 19) == 0);
                tick();
            end
        end
        key_new = 1'b0;
        start   = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
